// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Definitions shared by the ALU top and its multi-cycle issue sequencer:
//   - op_mode_e   : i_op_mode encodings understood by the ALU
//   - seq_state_e : state encoding of the mul/div sequencer
//   - DIV_ZERO_QUOTIENT and div_zero_result(): the value a divide by zero
//     returns without ever launching the divider.
// -----------------------------------------------------------------------------
package alu_pkg;

  typedef enum logic [2:0] {
    MODE_LOGIC       = 3'd0,
    MODE_SHIFT       = 3'd1,
    MODE_INT_ADD_SUB = 3'd2,
    MODE_INT_MUL     = 3'd3,
    MODE_INT_DIV     = 3'd4
  } op_mode_e;

  typedef enum logic [2:0] {
    SEQ_IDLE     = 3'd0,
    SEQ_MUL_WAIT = 3'd1,
    SEQ_DIV_WAIT = 3'd2,
    SEQ_DONE     = 3'd3,
    SEQ_DRAIN    = 3'd4
  } seq_state_e;

  localparam logic [31:0] DIV_ZERO_QUOTIENT = 32'hFFFF_FFFF;

  // x / 0 yields all-ones as quotient and the dividend itself as remainder.
  function automatic logic [31:0] div_zero_result(input logic        want_rem,
                                                  input logic [31:0] dividend);
    return want_rem ? dividend : DIV_ZERO_QUOTIENT;
  endfunction

endpackage

// File: rtl/alu_muldiv_seq_if.sv
// -----------------------------------------------------------------------------
// alu_muldiv_seq_if
// Bundles every non-clock signal of the mul/div issue sequencer:
//   execute side : i_req_valid, i_op_mode, i_func_op, i_a, i_b, i_flush,
//                  o_stall, o_result_valid, o_result, o_error
//   int_mul side : o_mul_valid, o_mul_a, o_mul_b, i_mul_valid, i_mul_result
//   int_div side : o_div_valid, o_div_a, o_div_b, i_div_valid,
//                  i_div_quotient, i_div_remainder
// The i_/o_ prefixes are from the sequencer's point of view.
//   slave  : the sequencer itself
//   master : its environment (execute stage plus the two units)
// -----------------------------------------------------------------------------
interface alu_muldiv_seq_if;

  logic        i_req_valid;
  logic [2:0]  i_op_mode;
  logic [1:0]  i_func_op;
  logic [31:0] i_a;
  logic [31:0] i_b;
  logic        i_flush;

  logic        o_stall;
  logic        o_result_valid;
  logic [31:0] o_result;
  logic        o_error;

  logic        o_mul_valid;
  logic [31:0] o_mul_a;
  logic [31:0] o_mul_b;
  logic        i_mul_valid;
  logic [31:0] i_mul_result;

  logic        o_div_valid;
  logic [31:0] o_div_a;
  logic [31:0] o_div_b;
  logic        i_div_valid;
  logic [31:0] i_div_quotient;
  logic [31:0] i_div_remainder;

  modport slave (
    input  i_req_valid, i_op_mode, i_func_op, i_a, i_b, i_flush,
    output o_stall, o_result_valid, o_result, o_error,
    output o_mul_valid, o_mul_a, o_mul_b,
    input  i_mul_valid, i_mul_result,
    output o_div_valid, o_div_a, o_div_b,
    input  i_div_valid, i_div_quotient, i_div_remainder
  );

  modport master (
    output i_req_valid, i_op_mode, i_func_op, i_a, i_b, i_flush,
    input  o_stall, o_result_valid, o_result, o_error,
    input  o_mul_valid, o_mul_a, o_mul_b,
    output i_mul_valid, i_mul_result,
    input  o_div_valid, o_div_a, o_div_b,
    output i_div_valid, i_div_quotient, i_div_remainder
  );

endinterface

// File: rtl/alu_muldiv_seq.sv
// -----------------------------------------------------------------------------
// alu_muldiv_seq
// Issue-side sequencer for the ALU's multi-cycle units (int_mul, int_div).
// Accepts one mul/div request from execute, stalls the pipeline while it is in
// flight, launches the selected unit with a one-cycle valid pulse, waits for
// the unit's valid response and returns a single-cycle result strobe.
// Also handles divide-by-zero without a launch, flush (with drain of the
// pending response) and a response watchdog.
//
// Ports:
//   i_clk  : clock
//   i_rst  : asynchronous active-high reset
//   bus    : alu_muldiv_seq_if.slave (execute, int_mul and int_div signals)
//
// Parameters:
//   TIMEOUT_CYCLES : cycles to wait for a unit response before completing with
//                    o_error=1 (must be at least 2)
//   OP_INT_MUL     : i_op_mode code for multiply
//   OP_INT_DIV     : i_op_mode code for divide
// -----------------------------------------------------------------------------
module alu_muldiv_seq
  import alu_pkg::*;
#(
  parameter int         TIMEOUT_CYCLES = 64,
  parameter logic [2:0] OP_INT_MUL     = MODE_INT_MUL,
  parameter logic [2:0] OP_INT_DIV     = MODE_INT_DIV
) (
  input logic              i_clk,
  input logic              i_rst,
  alu_muldiv_seq_if.slave  bus
);

  localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  seq_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      opa_q, opa_d;
  logic [31:0]      opb_q, opb_d;
  logic             func_q, func_d;
  logic             pend_div_q, pend_div_d;
  logic [31:0]      result_q, result_d;
  logic             error_q, error_d;
  logic             result_valid_q, result_valid_d;
  logic             mul_valid_q, mul_valid_d;
  logic             div_valid_q, div_valid_d;

  logic        is_mul;
  logic        is_div;
  logic        md_req;
  logic        unit_done;
  logic [31:0] unit_data;
  logic        timed_out;
  logic        func_hi_unused;

  assign is_mul = (bus.i_op_mode == OP_INT_MUL);
  assign is_div = (bus.i_op_mode == OP_INT_DIV);
  assign md_req = bus.i_req_valid & (is_mul | is_div);

  // Only bit0 of func_op selects anything (quotient vs remainder).
  assign func_hi_unused = bus.i_func_op[1];

  // pend_div_q remembers which unit owes a response, so the WAIT and DRAIN
  // states listen only to that unit and ignore the other one.
  assign unit_done = pend_div_q ? bus.i_div_valid : bus.i_mul_valid;
  assign unit_data = pend_div_q ? (func_q ? bus.i_div_remainder : bus.i_div_quotient)
                                : bus.i_mul_result;
  assign timed_out = (cnt_q == CNT_LAST);

  // The result strobe releases the stall in the same cycle, so execute can
  // retire the op as it sees the result.
  assign bus.o_stall = md_req & ~result_valid_q & ~bus.i_flush;

  always_comb begin
    // NOTE: every _d gets a default before the case statement; a path that
    // leaves a signal unassigned in always_comb would infer a latch.
    state_d        = state_q;
    cnt_d          = cnt_q;
    opa_d          = opa_q;
    opb_d          = opb_q;
    func_d         = func_q;
    pend_div_d     = pend_div_q;
    result_d       = result_q;
    error_d        = error_q;
    result_valid_d = 1'b0;
    mul_valid_d    = 1'b0;
    div_valid_d    = 1'b0;

    unique case (state_q)
      SEQ_IDLE: begin
        if (md_req && !bus.i_flush) begin
          func_d = bus.i_func_op[0];
          if (is_div && (bus.i_b == '0)) begin
            // Divide by zero completes next cycle without touching int_div.
            state_d        = SEQ_DONE;
            result_valid_d = 1'b1;
            result_d       = div_zero_result(bus.i_func_op[0], bus.i_a);
            error_d        = 1'b0;
          end else begin
            opa_d       = bus.i_a;
            opb_d       = bus.i_b;
            pend_div_d  = is_div;
            mul_valid_d = ~is_div;
            div_valid_d = is_div;
            state_d     = is_div ? SEQ_DIV_WAIT : SEQ_MUL_WAIT;
          end
        end
      end

      SEQ_MUL_WAIT, SEQ_DIV_WAIT: begin
        if (unit_done || timed_out) begin
          cnt_d = '0;
          if (bus.i_flush) begin
            // Response (or timeout) coincides with the flush: nothing is left
            // to drain, so discard and go straight back to idle.
            state_d = SEQ_IDLE;
          end else begin
            state_d        = SEQ_DONE;
            result_valid_d = 1'b1;
            result_d       = unit_done ? unit_data : '0;
            error_d        = ~unit_done;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (bus.i_flush) begin
            state_d = SEQ_DRAIN;
          end
        end
      end

      SEQ_DONE: begin
        state_d = SEQ_IDLE;
      end

      SEQ_DRAIN: begin
        // Swallow the aborted op's response so it cannot be mistaken for the
        // answer to the next request; the watchdog keeps running here too.
        if (unit_done || timed_out) begin
          cnt_d   = '0;
          state_d = SEQ_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = SEQ_IDLE;
      end
    endcase
  end

  // NOTE: state flops use non-blocking assignment so every flop samples the
  // pre-edge value of the others, independent of statement order.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q        <= SEQ_IDLE;
      cnt_q          <= '0;
      opa_q          <= '0;
      opb_q          <= '0;
      func_q         <= 1'b0;
      pend_div_q     <= 1'b0;
      result_q       <= '0;
      error_q        <= 1'b0;
      result_valid_q <= 1'b0;
      mul_valid_q    <= 1'b0;
      div_valid_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      opa_q          <= opa_d;
      opb_q          <= opb_d;
      func_q         <= func_d;
      pend_div_q     <= pend_div_d;
      result_q       <= result_d;
      error_q        <= error_d;
      result_valid_q <= result_valid_d;
      mul_valid_q    <= mul_valid_d;
      div_valid_q    <= div_valid_d;
    end
  end

  assign bus.o_result_valid = result_valid_q;
  assign bus.o_result       = result_q;
  assign bus.o_error        = error_q;

  // One operand register pair feeds both units; only one is ever launched.
  assign bus.o_mul_valid = mul_valid_q;
  assign bus.o_mul_a     = opa_q;
  assign bus.o_mul_b     = opb_q;
  assign bus.o_div_valid = div_valid_q;
  assign bus.o_div_a     = opa_q;
  assign bus.o_div_b     = opb_q;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// -----------------------------------------------------------------------------
// tb_alu_muldiv_seq
// Directed bench for alu_muldiv_seq (TIMEOUT_CYCLES=8). The bench plays the
// execute stage and both units. A transaction-level model tracks the one op
// in flight by elapsed cycles and predicts strobes, result and error; a
// compare process checks every cycle, and each directed scenario also checks
// hand-computed latencies and values.
// -----------------------------------------------------------------------------
module tb_alu_muldiv_seq;

  localparam int         TO     = 8;
  localparam logic [2:0] OP_MUL = 3'd3;
  localparam logic [2:0] OP_DIV = 3'd4;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  alu_muldiv_seq_if bus ();

  alu_muldiv_seq #(
    .TIMEOUT_CYCLES(TO),
    .OP_INT_MUL    (OP_MUL),
    .OP_INT_DIV    (OP_DIV)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- model
  // m_busy: 0 none, 1 multiply pending, 2 divide pending.
  int          m_busy = 0;
  int          m_wait = 0;
  bit          m_drain = 0;
  bit          m_func = 0;
  bit          m_rv = 0;
  bit          m_err = 0;
  bit          m_mulv = 0;
  bit          m_divv = 0;
  logic [31:0] m_res = '0;
  logic [31:0] m_a = '0;
  logic [31:0] m_b = '0;

  function automatic bit md_req_now();
    return bus.i_req_valid && (bus.i_op_mode == OP_MUL || bus.i_op_mode == OP_DIV);
  endfunction

  // Advances the model by one clock using the inputs of the cycle just ended.
  task automatic model_step();
    bit was_done;
    bit resp;
    was_done = m_rv;
    m_rv   = 0;
    m_mulv = 0;
    m_divv = 0;
    if (m_busy != 0) begin
      m_wait++;
      resp = (m_busy == 1) ? bus.i_mul_valid : bus.i_div_valid;
      if (resp || m_wait == TO) begin
        if (!m_drain && !bus.i_flush) begin
          m_rv  = 1;
          m_err = !resp;
          if (!resp)           m_res = '0;
          else if (m_busy == 1) m_res = bus.i_mul_result;
          else                  m_res = m_func ? bus.i_div_remainder : bus.i_div_quotient;
        end
        m_busy  = 0;
        m_drain = 0;
      end else if (bus.i_flush) begin
        m_drain = 1;
      end
    end else if (!was_done && md_req_now() && !bus.i_flush) begin
      m_func = bus.i_func_op[0];
      if (bus.i_op_mode == OP_DIV && bus.i_b == 0) begin
        m_rv  = 1;
        m_err = 0;
        m_res = bus.i_func_op[0] ? bus.i_a : 32'hFFFF_FFFF;
      end else begin
        m_busy = (bus.i_op_mode == OP_MUL) ? 1 : 2;
        m_wait = 0;
        m_a    = bus.i_a;
        m_b    = bus.i_b;
        m_mulv = (m_busy == 1);
        m_divv = (m_busy == 2);
      end
    end
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      m_busy = 0; m_wait = 0; m_drain = 0; m_func = 0;
      m_rv = 0; m_err = 0; m_mulv = 0; m_divv = 0;
      m_res = '0; m_a = '0; m_b = '0;
    end else begin
      model_step();
    end
  end

  // Compare process: every cycle, away from the active edge.
  initial forever begin
    @(negedge clk);
    check("cmp_result_valid", 32'(bus.o_result_valid), 32'(m_rv));
    check("cmp_result",       bus.o_result,             m_res);
    check("cmp_error",        32'(bus.o_error),         32'(m_err));
    check("cmp_mul_valid",    32'(bus.o_mul_valid),     32'(m_mulv));
    check("cmp_div_valid",    32'(bus.o_div_valid),     32'(m_divv));
    check("cmp_stall", 32'(bus.o_stall),
          32'(md_req_now() && !m_rv && !bus.i_flush));
    if (m_mulv) begin
      check("cmp_mul_a", bus.o_mul_a, m_a);
      check("cmp_mul_b", bus.o_mul_b, m_b);
    end
    if (m_divv) begin
      check("cmp_div_a", bus.o_div_a, m_a);
      check("cmp_div_b", bus.o_div_b, m_b);
    end
  end

  // ------------------------------------------------------------- stimulus
  task automatic idle_inputs();
    bus.i_req_valid     = 0;
    bus.i_op_mode       = 3'd0;
    bus.i_func_op       = 2'd0;
    bus.i_a             = '0;
    bus.i_b             = '0;
    bus.i_flush         = 0;
    bus.i_mul_valid     = 0;
    bus.i_mul_result    = 32'hDEAD_BEEF;
    bus.i_div_valid     = 0;
    bus.i_div_quotient  = 32'hBAD0_0001;
    bus.i_div_remainder = 32'hBAD0_0002;
  endtask

  // Plays the unit for the requested op; result buses carry junk unless firing.
  task automatic drive_units(input logic [2:0] mode, input logic [31:0] a,
                             input logic [31:0] b, input bit fire);
    bus.i_mul_valid     = fire && (mode == OP_MUL);
    bus.i_mul_result    = fire ? a * b : 32'hDEAD_BEEF;
    bus.i_div_valid     = fire && (mode == OP_DIV);
    bus.i_div_quotient  = (fire && b != 0) ? a / b : 32'hBAD0_0001;
    bus.i_div_remainder = (fire && b != 0) ? a % b : 32'hBAD0_0002;
  endtask

  // Presents one request at offset 0 and holds it until the result strobe.
  // lat < 0 means the unit never answers. Offsets are cycles from the request.
  task automatic run_op(input logic [2:0] mode, input logic [1:0] func,
                        input logic [31:0] a, input logic [31:0] b,
                        input int lat, input int budget,
                        output int rv_off, output int strobe_off,
                        output int n_strobe, output int n_stall,
                        output logic [31:0] res, output logic err);
    rv_off = -1; strobe_off = -1; n_strobe = 0; n_stall = 0; res = '0; err = 0;
    bus.i_req_valid = 1;
    bus.i_op_mode   = mode;
    bus.i_func_op   = func;
    bus.i_a         = a;
    bus.i_b         = b;
    for (int k = 0; k < budget; k++) begin
      drive_units(mode, a, b, lat >= 0 && k == lat + 1);
      @(negedge clk);
      if (bus.o_mul_valid || bus.o_div_valid) begin
        n_strobe++;
        if (strobe_off < 0) strobe_off = k;
      end
      if (bus.o_stall) n_stall++;
      if (bus.o_result_valid) begin
        rv_off = k;
        res    = bus.o_result;
        err    = bus.o_error;
      end
      @(posedge clk); #1;
      if (rv_off >= 0) break;
    end
    idle_inputs();
  endtask

  int          rv, so, ns, st;
  logic [31:0] res;
  logic        err;

  initial begin
    idle_inputs();
    rst = 1;
    #2;
    check("reset_result_valid", 32'(bus.o_result_valid), 0);
    check("reset_result",       bus.o_result, 0);
    check("reset_error",        32'(bus.o_error), 0);
    check("reset_mul_valid",    32'(bus.o_mul_valid), 0);
    check("reset_div_valid",    32'(bus.o_div_valid), 0);
    check("reset_mul_a",        bus.o_mul_a, 0);
    check("reset_div_b",        bus.o_div_b, 0);
    check("reset_stall",        32'(bus.o_stall), 0);
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(posedge clk); #1;

    // 7 x 6, unit latency 3: strobe at 1, result at 5, stalled 0..4.
    run_op(OP_MUL, 2'd0, 32'd7, 32'd6, 3, 20, rv, so, ns, st, res, err);
    check("mul_rv_cycle",     rv, 5);
    check("mul_strobe_cycle", so, 1);
    check("mul_strobe_count", ns, 1);
    check("mul_stall_cycles", st, 5);
    check("mul_result",       res, 42);
    check("mul_error",        32'(err), 0);

    // 100 / 7 remainder (latency 5) then quotient (latency 1).
    run_op(OP_DIV, 2'd1, 32'd100, 32'd7, 5, 20, rv, so, ns, st, res, err);
    check("div_rem_rv_cycle", rv, 7);
    check("div_rem_result",   res, 2);
    run_op(OP_DIV, 2'd0, 32'd100, 32'd7, 1, 20, rv, so, ns, st, res, err);
    check("div_quo_rv_cycle", rv, 3);
    check("div_quo_result",   res, 14);
    check("div_quo_strobe",   so, 1);

    // Divide by zero: no launch, result next cycle.
    run_op(OP_DIV, 2'd0, 32'h1234_5678, 32'd0, -1, 20, rv, so, ns, st, res, err);
    check("div0_quo_rv_cycle", rv, 1);
    check("div0_quo_result",   res, 32'hFFFF_FFFF);
    check("div0_quo_strobes",  ns, 0);
    check("div0_quo_stall",    st, 1);
    run_op(OP_DIV, 2'd1, 32'h1234_5678, 32'd0, -1, 20, rv, so, ns, st, res, err);
    check("div0_rem_rv_cycle", rv, 1);
    check("div0_rem_result",   res, 32'h1234_5678);

    // Non mul/div ops: no stall, strobe or result.
    run_op(3'd0, 2'd0, 32'd3, 32'd4, -1, 4, rv, so, ns, st, res, err);
    check("logic_no_result", rv, -1);
    check("logic_no_strobe", ns, 0);
    check("logic_no_stall",  st, 0);
    run_op(3'd2, 2'd0, 32'd3, 32'd0, -1, 4, rv, so, ns, st, res, err);
    check("addsub_no_result", rv, -1);
    check("addsub_no_stall",  st, 0);

    // Unsolicited unit valids while idle.
    bus.i_mul_valid = 1; bus.i_div_valid = 1;
    @(negedge clk);
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    check("unsolicited_ignored", 32'(bus.o_result_valid), 0);
    @(posedge clk); #1;

    // Watchdog: multiply that never answers completes with error at 1+TO.
    run_op(OP_MUL, 2'd0, 32'd5, 32'd5, -1, 20, rv, so, ns, st, res, err);
    check("timeout_rv_cycle", rv, 9);
    check("timeout_result",   res, 0);
    check("timeout_error",    32'(err), 1);
    run_op(OP_DIV, 2'd1, 32'd100, 32'd7, 2, 20, rv, so, ns, st, res, err);
    check("after_timeout_result", res, 2);
    check("after_timeout_error",  32'(err), 0);

    // Flush during DIV_WAIT; new mul waits for the drain of the stale div.
    begin
      int div_strobes = 0;
      int mul_so = -1;
      int rv_at = -1;
      logic [31:0] r = '0;
      bus.i_req_valid = 1; bus.i_op_mode = OP_DIV; bus.i_func_op = 2'd0;
      bus.i_a = 32'd100; bus.i_b = 32'd7;
      for (int k = 0; k < 25; k++) begin
        bus.i_flush = (k == 2);
        if (k == 3) begin
          bus.i_op_mode = OP_MUL; bus.i_a = 32'd9; bus.i_b = 32'd5;
        end
        drive_units(OP_DIV, 32'd100, 32'd7, k == 6);
        if (k == 4) begin
          bus.i_mul_valid = 1; bus.i_mul_result = 32'h11;
        end
        if (mul_so >= 0 && k == mul_so + 2) begin
          bus.i_mul_valid = 1; bus.i_mul_result = 32'd45;
        end
        @(negedge clk);
        if (bus.o_div_valid) div_strobes++;
        if (bus.o_mul_valid && mul_so < 0) mul_so = k;
        if (bus.o_result_valid && rv_at < 0) begin
          rv_at = k; r = bus.o_result;
        end
        @(posedge clk); #1;
        bus.i_mul_valid = 0; bus.i_div_valid = 0;
        if (rv_at >= 0) break;
      end
      idle_inputs();
      check("flush_div_strobes",    div_strobes, 1);
      check("flush_mul_launch",     mul_so, 8);
      check("flush_first_result",   rv_at, 11);
      check("flush_mul_result",     r, 45);
    end

    // Reset in MUL_WAIT, then a late unit response.
    bus.i_req_valid = 1; bus.i_op_mode = OP_MUL; bus.i_a = 32'd3; bus.i_b = 32'd4;
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst = 1;
    idle_inputs();
    #1;
    check("midrst_result",       bus.o_result, 0);
    check("midrst_result_valid", 32'(bus.o_result_valid), 0);
    check("midrst_mul_valid",    32'(bus.o_mul_valid), 0);
    check("midrst_mul_a",        bus.o_mul_a, 0);
    check("midrst_stall",        32'(bus.o_stall), 0);
    @(posedge clk); #1;
    rst = 0;
    @(posedge clk); #1;
    bus.i_mul_valid = 1; bus.i_mul_result = 32'd12;
    @(negedge clk);
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    check("late_valid_ignored", 32'(bus.o_result_valid), 0);
    @(posedge clk); #1;
    run_op(OP_MUL, 2'd0, 32'd3, 32'd4, 2, 20, rv, so, ns, st, res, err);
    check("post_rst_rv_cycle", rv, 4);
    check("post_rst_result",   res, 12);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, got running want done");
    $fatal(1);
  end

endmodule

// File: doc/alu_muldiv_seq.md
Name: alu_muldiv_seq

Overview:
Issue-side sequencer for the ALU's multi-cycle integer units (int_mul, int_div). It accepts a mul/div request from the execute stage and stalls the pipeline while the request is in flight. It launches the selected unit with a one-cycle valid pulse, waits for that unit's valid response, then returns a single-cycle result.
It is the initiator end of the i_valid/o_valid handshake that int_mul and int_div respond to. It also owns divide-by-zero short-circuiting, flush/drain and a watchdog timeout.

Parameters:
TIMEOUT_CYCLES, 64, maximum cycles to wait for a unit response before forcing error completion (must be at least 2).
OP_INT_MUL, 3, i_op_mode code for multiply.
OP_INT_DIV, 4, i_op_mode code for divide.

Ports:
- i_clk  in  1  clock, the only clock.
- i_rst  in  1  reset, asynchronous, active-high.
- i_req_valid  in  1  execute stage presents an op; held stable while o_stall=1.
- i_op_mode  in  3  ALU op mode; only OP_INT_MUL and OP_INT_DIV are acted on.
- i_func_op  in  2  for div, bit0: 0 = quotient, 1 = remainder; ignored for mul.
- i_a, i_b  in  32 each  operands.
- i_flush  in  1  abort any in-flight op.
- o_stall  out  1  hold the pipeline.
- o_result_valid  out  1  one-cycle result strobe.
- o_result  out  32  result.
- o_error  out  1  qualifies o_result_valid; timeout occurred.
- o_mul_valid  out  1  launch strobe to int_mul.
- o_mul_a, o_mul_b  out  32 each  operands to int_mul.
- i_mul_valid  in  1  int_mul done.
- i_mul_result  in  32  int_mul result.
- o_div_valid  out  1  launch strobe to int_div.
- o_div_a, o_div_b  out  32 each  operands to int_div.
- i_div_valid  in  1  int_div done.
- i_div_quotient  in  32  int_div quotient.
- i_div_remainder  in  32  int_div remainder.

Behaviour:
- Reset: state IDLE; all outputs 0, including registered operands; timeout counter 0. Reset mid-operation abandons the op with no drain; the unit's later response arrives in IDLE and is ignored.
- Request type: md_req = i_req_valid & (i_op_mode == OP_INT_MUL or OP_INT_DIV). Other ops never stall and never produce o_result_valid.
- Stall (combinational): o_stall = md_req & ~o_result_valid & ~i_flush.
- States: IDLE, MUL_WAIT, DIV_WAIT, DONE, DRAIN.
- IDLE, md_req at cycle T, no flush:
  - mul: register operands, go to MUL_WAIT; o_mul_valid=1 during T+1 only.
  - div with i_b != 0: same path, going to DIV_WAIT with o_div_valid.
  - div with i_b == 0: no launch. Go to DONE; result is 0xFFFFFFFF for quotient, i_a for remainder.
- MUL_WAIT / DIV_WAIT: the counter increments each cycle.
  - The matching unit valid captures its result (selected by the registered func_op bit0) and moves to DONE.
  - If the counter reaches TIMEOUT_CYCLES-1 with no response, go to DONE with o_result=0 and o_error=1.
  - The counter clears on exit.
- DONE: o_result_valid=1 for exactly one cycle, o_stall=0, then IDLE. o_result holds its value until the next DONE; o_error clears on the next DONE.
- Latency: with unit latency L (unit valid at T+1+L), o_result_valid is high at T+2+L. Divide-by-zero result is valid at T+1.
- Flush:
  - In IDLE or DONE: no effect beyond o_stall=0.
  - In a WAIT state: go to DRAIN, no o_result_valid. DRAIN waits for the pending unit valid or the timeout, discards it, then returns to IDLE.
  - md_req is not accepted in DRAIN (o_stall stays asserted if a request is present).
- Unsolicited unit valid in IDLE, or from the non-pending unit: ignored.
- Only one op is in flight at a time; launch strobes are never asserted outside the cycle after acceptance.

Decomposition:
- Shared package alu_pkg holds:
  - the op-mode codes (LOGIC=0, SHIFT=1, INT_ADD_SUB=2, INT_MUL=3, INT_DIV=4), shared with the alu top;
  - the sequencer state encoding;
  - DIV_ZERO_QUOTIENT = 32'hFFFFFFFF.
- No sub-module is needed; the timeout counter stays inline.

Test Plan:
- mul 7×6, unit latency 3, request at cycle 0 -> o_mul_valid at cycle 1 only; o_result=42, o_result_valid at cycle 5; o_stall high for cycles 0–4.
- div 100/7 with func_op=1, then func_op=0 -> results 2 and 14, each after unit latency plus 2.
- div 0x12345678 / 0 -> no o_div_valid; result at T+1 is 0xFFFFFFFF; with func_op=1 the result is 0x12345678.
- Flush during DIV_WAIT, new mul request presented, stale div valid arrives 4 cycles later -> no result for the div; mul is launched only after the drain; mul result is correct.
- Unit never responds, TIMEOUT_CYCLES=8 -> o_result_valid with o_error=1 and o_result=0 at T+9.
- Assert i_rst during MUL_WAIT, then send a late i_mul_valid -> all outputs 0 immediately; the late valid is ignored; the next request completes normally.
- Logic op (mode 0) with i_req_valid=1 -> o_stall=0, no strobes, no result.
